// File: rtl/dram_arbiter.sv
// Shares the single-port data RAM between the CPU data bus and the SPI host path.
// One access at a time through IDLE -> ACCESS -> RESP -> DONE. The CPU has priority, bounded by a starvation counter.

module dram_arbiter #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            cpu_rst_n_i,

   input  logic            cpu_req_i,
   input  logic            cpu_wr_i,
   input  logic [XLEN-1:0] cpu_addr_i,
   input  logic [31:0]     cpu_wdata_i,
   input  logic [3:0]      cpu_be_i,
   output logic            cpu_ack_o,
   output logic [31:0]     cpu_rdata_o,

   input  logic            host_req_i,
   input  logic            host_wr_i,
   input  logic [XLEN-1:0] host_addr_i,
   input  logic [31:0]     host_wdata_i,
   input  logic [3:0]      host_be_i,
   output logic            host_ack_o,
   output logic [31:0]     host_rdata_o,

   output logic            ram_en_o,
   output logic [3:0]      ram_we_o,
   output logic [XLEN-1:0] ram_addr_o,
   output logic [31:0]     ram_wdata_o,
   input  logic [31:0]     ram_rdata_i,

   output logic [1:0]      dbg_state_o
);

   // Handshake: a requester raises req with stable wr/addr/wdata/be and holds it until
   // its one-cycle ack. In the ack cycle and the cycle after it, it may drop req or present
   // a new request; the arbiter samples requests only in IDLE.

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_DONE} state_e;
   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_HOST} owner_e;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_e            state_q;
   owner_e            owner_q;
   logic [3:0]        starve_cnt_q, starve_cnt_d;

   logic              ram_en_q;
   logic [3:0]        ram_we_q;
   logic [XLEN-1:0]   ram_addr_q;
   logic [31:0]       ram_wdata_q;
   logic              cpu_ack_q, host_ack_q;
   logic [31:0]       cpu_rdata_q, host_rdata_q;

   logic              cpu_elig, host_elig, starved;
   logic              grant_cpu, grant_host;

   always_comb begin
      cpu_elig   = cpu_req_i & cpu_rst_n_i;
      host_elig  = host_req_i;
      starved    = (starve_cnt_q >= STARVE_LIM);
      grant_cpu  = cpu_elig & (~host_elig | ~starved);
      grant_host = host_elig & (~cpu_elig | starved);
   end

   // The counter only measures CPU wins while the host is actually waiting.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (state_q == S_IDLE) begin
         if (!host_req_i || grant_host) begin
            starve_cnt_d = 4'd0;
         end else if (grant_cpu && (starve_cnt_q < STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_NONE;
         starve_cnt_q <= 4'd0;
         ram_en_q     <= 1'b0;
         ram_we_q     <= 4'd0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= 32'd0;
         cpu_ack_q    <= 1'b0;
         host_ack_q   <= 1'b0;
         cpu_rdata_q  <= 32'd0;
         host_rdata_q <= 32'd0;
      end else begin
         ram_en_q     <= 1'b0;
         ram_we_q     <= 4'd0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= 32'd0;
         cpu_ack_q    <= 1'b0;
         host_ack_q   <= 1'b0;
         starve_cnt_q <= starve_cnt_d;

         case (state_q)
            S_IDLE: begin
               if (grant_cpu) begin
                  owner_q     <= OWN_CPU;
                  state_q     <= S_ACCESS;
                  ram_en_q    <= 1'b1;
                  ram_we_q    <= {4{cpu_wr_i}} & cpu_be_i;
                  ram_addr_q  <= cpu_addr_i;
                  ram_wdata_q <= cpu_wdata_i;
               end else if (grant_host) begin
                  owner_q     <= OWN_HOST;
                  state_q     <= S_ACCESS;
                  ram_en_q    <= 1'b1;
                  ram_we_q    <= {4{host_wr_i}} & host_be_i;
                  ram_addr_q  <= host_addr_i;
                  ram_wdata_q <= host_wdata_i;
               end
            end

            S_ACCESS: begin
               state_q <= S_RESP;
            end

            // RAM data for the ACCESS cycle is valid now; writes capture don't-care data.
            S_RESP: begin
               state_q <= S_DONE;
               if (owner_q == OWN_CPU) begin
                  cpu_rdata_q <= ram_rdata_i;
                  cpu_ack_q   <= 1'b1;
               end else if (owner_q == OWN_HOST) begin
                  host_rdata_q <= ram_rdata_i;
                  host_ack_q   <= 1'b1;
               end
            end

            S_DONE: begin
               state_q <= S_IDLE;
               owner_q <= OWN_NONE;
            end

            default: begin
               state_q <= S_IDLE;
               owner_q <= OWN_NONE;
            end
         endcase
      end
   end

   assign ram_en_o     = ram_en_q;
   assign ram_we_o     = ram_we_q;
   assign ram_addr_o   = ram_addr_q;
   assign ram_wdata_o  = ram_wdata_q;
   assign cpu_ack_o    = cpu_ack_q;
   assign cpu_rdata_o  = cpu_rdata_q;
   assign host_ack_o   = host_ack_q;
   assign host_rdata_o = host_rdata_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed accesses from both requesters against a byte-enable RAM model.
// Expected RAM strobes and acks are queued at issue time and popped by a negedge monitor.

module tb_dram_arbiter;

   localparam int XLEN       = 32;
   localparam int STARVE_MAX = 4;
   localparam int ACK_W      = 34;           // {check_data, is_host, rdata}
   localparam int RAM_W      = 4 + XLEN + 32; // {we, addr, wdata}

   logic            clk_i = 1'b0;
   logic            rst_n_i;
   logic            cpu_rst_n_i;
   logic            cpu_req_i, cpu_wr_i;
   logic [XLEN-1:0] cpu_addr_i;
   logic [31:0]     cpu_wdata_i;
   logic [3:0]      cpu_be_i;
   logic            cpu_ack_o;
   logic [31:0]     cpu_rdata_o;
   logic            host_req_i, host_wr_i;
   logic [XLEN-1:0] host_addr_i;
   logic [31:0]     host_wdata_i;
   logic [3:0]      host_be_i;
   logic            host_ack_o;
   logic [31:0]     host_rdata_o;
   logic            ram_en_o;
   logic [3:0]      ram_we_o;
   logic [XLEN-1:0] ram_addr_o;
   logic [31:0]     ram_wdata_o;
   logic [31:0]     ram_rdata_i;
   logic [1:0]      dbg_state_o;

   logic [ACK_W-1:0] exp_q[$];
   logic [RAM_W-1:0] ram_q[$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int last_ack_cyc = -1;
   logic chk_gap = 1'b0;

   dram_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .cpu_rst_n_i(cpu_rst_n_i),
      .cpu_req_i(cpu_req_i), .cpu_wr_i(cpu_wr_i), .cpu_addr_i(cpu_addr_i),
      .cpu_wdata_i(cpu_wdata_i), .cpu_be_i(cpu_be_i), .cpu_ack_o(cpu_ack_o),
      .cpu_rdata_o(cpu_rdata_o),
      .host_req_i(host_req_i), .host_wr_i(host_wr_i), .host_addr_i(host_addr_i),
      .host_wdata_i(host_wdata_i), .host_be_i(host_be_i), .host_ack_o(host_ack_o),
      .host_rdata_o(host_rdata_o),
      .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
      .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
      .dbg_state_o(dbg_state_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   // ---------------- RAM model (read-first, byte enables) ----------------
   logic [31:0] mem [logic [31:0]];
   logic [31:0] ram_cur;

   always @(posedge clk_i) begin
      if (ram_en_o) begin
         ram_cur = mem.exists(ram_addr_o) ? mem[ram_addr_o] : 32'h0;
         ram_rdata_i <= ram_cur;
         for (int b = 0; b < 4; b++) begin
            if (ram_we_o[b]) ram_cur[8*b +: 8] = ram_wdata_o[8*b +: 8];
         end
         mem[ram_addr_o] = ram_cur;
      end
   end

   // ---------------- checking helper ----------------
   task automatic chk(input string name, input logic [RAM_W-1:0] act, input logic [RAM_W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk_i) begin
      logic [RAM_W-1:0] re;
      logic [ACK_W-1:0] ae;
      if (ram_en_o) begin
         if (ram_q.size() == 0) begin
            chk("ram_unexpected_en", 1'b1, 1'b0);
         end else begin
            re = ram_q.pop_front();
            chk("ram_access", {ram_we_o, ram_addr_o, ram_wdata_o}, re);
         end
      end else begin
         chk("ram_idle_zero", {ram_we_o, ram_addr_o, ram_wdata_o}, '0);
      end
      if (cpu_ack_o || host_ack_o) begin
         chk("ack_onehot", cpu_ack_o & host_ack_o, 1'b0);
         if (exp_q.size() == 0) begin
            chk("ack_unexpected", 1'b1, 1'b0);
         end else begin
            ae = exp_q.pop_front();
            chk("ack_owner", host_ack_o, ae[32]);
            if (ae[33]) chk("ack_rdata", host_ack_o ? host_rdata_o : cpu_rdata_o, ae[31:0]);
         end
         if (chk_gap) begin
            if (last_ack_cyc >= 0) chk("ack_gap", cyc - last_ack_cyc, 4);
            last_ack_cyc = cyc;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cpu_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be);
      int n;
      cpu_wr_i = wr; cpu_addr_i = addr; cpu_wdata_i = wdata; cpu_be_i = be;
      cpu_req_i = 1'b1;
      n = 0;
      do begin @(negedge clk_i); n++; end while (!cpu_ack_o && n < 40);
      if (!cpu_ack_o) chk("cpu_ack_timeout", 1'b0, 1'b1);
      cpu_req_i = 1'b0;
   endtask

   task automatic host_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be);
      int n;
      host_wr_i = wr; host_addr_i = addr; host_wdata_i = wdata; host_be_i = be;
      host_req_i = 1'b1;
      n = 0;
      do begin @(negedge clk_i); n++; end while (!host_ack_o && n < 40);
      if (!host_ack_o) chk("host_ack_timeout", 1'b0, 1'b1);
      host_req_i = 1'b0;
   endtask

   task automatic clear_inputs();
      cpu_rst_n_i = 1'b0;
      cpu_req_i = 1'b0; cpu_wr_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0; cpu_be_i = '0;
      host_req_i = 1'b0; host_wr_i = 1'b0; host_addr_i = '0; host_wdata_i = '0; host_be_i = '0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      rst_n_i = 1'b0;
      ram_rdata_i = 32'h0;
      clear_inputs();

      // Reset with random inputs toggling
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         cpu_rst_n_i = 1'($urandom_range(0, 1));
         cpu_req_i = 1'($urandom_range(0, 1)); cpu_wr_i = 1'($urandom_range(0, 1));
         cpu_addr_i = $urandom; cpu_wdata_i = $urandom; cpu_be_i = 4'($urandom_range(0, 15));
         host_req_i = 1'($urandom_range(0, 1)); host_wr_i = 1'($urandom_range(0, 1));
         host_addr_i = $urandom; host_wdata_i = $urandom; host_be_i = 4'($urandom_range(0, 15));
         ram_rdata_i = $urandom;
         #1;
         chk("rst_ram_out", {ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o}, '0);
         chk("rst_ack_out", {cpu_ack_o, host_ack_o, cpu_rdata_o, host_rdata_o}, '0);
      end
      @(negedge clk_i);
      rst_n_i = 1'b1;
      #1;
      chk("idle_ram_out", {ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o}, '0);
      chk("idle_ack_out", {cpu_ack_o, host_ack_o, cpu_rdata_o, host_rdata_o}, '0);
      chk("idle_state", dbg_state_o, 2'd0);
      clear_inputs();
      repeat (2) @(negedge clk_i);

      // Host write while CPU is in reset, with per-cycle timing checks
      ram_q.push_back({4'hF, 32'h0002_0000, 32'hDEAD_BEEF});
      exp_q.push_back({1'b0, 1'b1, 32'h0});
      host_wr_i = 1'b1; host_addr_i = 32'h0002_0000; host_wdata_i = 32'hDEAD_BEEF; host_be_i = 4'hF;
      host_req_i = 1'b1;
      @(negedge clk_i);
      chk("hw_en", ram_en_o, 1'b1);
      chk("hw_we", ram_we_o, 4'hF);
      chk("hw_addr", ram_addr_o, 32'h0002_0000);
      @(negedge clk_i);
      chk("hw_en_off", ram_en_o, 1'b0);
      chk("hw_ack_early", host_ack_o, 1'b0);
      @(negedge clk_i);
      chk("hw_ack", host_ack_o, 1'b1);
      chk("hw_cpu_ack", cpu_ack_o, 1'b0);
      host_req_i = 1'b0;
      @(negedge clk_i);
      chk("hw_ack_pulse", host_ack_o, 1'b0);

      // Host read back, then check rdata holds after the ack
      ram_q.push_back({4'h0, 32'h0002_0000, 32'h0});
      exp_q.push_back({1'b1, 1'b1, 32'hDEAD_BEEF});
      host_access(1'b0, 32'h0002_0000, 32'h0, 4'hF);
      @(negedge clk_i);
      chk("hr_hold", host_rdata_o, 32'hDEAD_BEEF);

      // be=0 write: no byte written, ack still pulsed; read back unchanged data
      ram_q.push_back({4'h0, 32'h0002_0000, 32'h1111_1111});
      exp_q.push_back({1'b0, 1'b1, 32'h0});
      host_access(1'b1, 32'h0002_0000, 32'h1111_1111, 4'h0);
      ram_q.push_back({4'h0, 32'h0002_0000, 32'h0});
      exp_q.push_back({1'b1, 1'b1, 32'hDEAD_BEEF});
      host_access(1'b0, 32'h0002_0000, 32'h0, 4'hF);

      // CPU request ignored while CPU is in reset, served once released
      cpu_rst_n_i = 1'b0;
      cpu_wr_i = 1'b1; cpu_addr_i = 32'h0000_0100; cpu_wdata_i = 32'h1234_5678; cpu_be_i = 4'h3;
      cpu_req_i = 1'b1;
      n = 0;
      repeat (8) begin
         @(negedge clk_i);
         if (ram_en_o || cpu_ack_o) n++;
      end
      chk("cpu_held_off", n, 0);
      ram_q.push_back({4'h3, 32'h0000_0100, 32'h1234_5678});
      exp_q.push_back({1'b0, 1'b0, 32'h0});
      cpu_rst_n_i = 1'b1;
      @(negedge clk_i);
      chk("cpu_wake_en", ram_en_o, 1'b1);
      n = 0;
      while (!cpu_ack_o && n < 10) begin @(negedge clk_i); n++; end
      chk("cpu_wake_ack", cpu_ack_o, 1'b1);
      cpu_req_i = 1'b0;
      ram_q.push_back({4'h0, 32'h0000_0100, 32'h0});
      exp_q.push_back({1'b1, 1'b0, 32'h0000_5678});
      cpu_access(1'b0, 32'h0000_0100, 32'h0, 4'hF);
      repeat (2) @(negedge clk_i);

      // Both requesting continuously: C,C,C,C,H,C,C,C,C,H with acks 4 cycles apart
      for (int i = 0; i < 8; i++) mem[32'h1000 + 4*i] = 32'hC000_0000 + i;
      for (int j = 0; j < 2; j++) mem[32'h2000 + 4*j] = 32'hA000_0000 + j;
      for (int g = 0; g < 10; g++) begin
         if (g == 4 || g == 9) begin
            ram_q.push_back({4'h0, 32'h2000 + 32'(4*(g/5)), 32'h0});
            exp_q.push_back({1'b1, 1'b1, 32'hA000_0000 + 32'(g/5)});
         end else begin
            ram_q.push_back({4'h0, 32'h1000 + 32'(4*(g - g/5)), 32'h0});
            exp_q.push_back({1'b1, 1'b0, 32'hC000_0000 + 32'(g - g/5)});
         end
      end
      last_ack_cyc = -1;
      chk_gap = 1'b1;
      fork
         for (int i = 0; i < 8; i++) cpu_access(1'b0, 32'h1000 + 32'(4*i), 32'h0, 4'hF);
         for (int j = 0; j < 2; j++) host_access(1'b0, 32'h2000 + 32'(4*j), 32'h0, 4'hF);
      join
      chk_gap = 1'b0;
      repeat (2) @(negedge clk_i);

      // Reset asserted during ACCESS aborts the access; host is served afresh after release
      cpu_rst_n_i = 1'b0;
      ram_q.push_back({4'h0, 32'h0002_0000, 32'h0});
      host_wr_i = 1'b0; host_addr_i = 32'h0002_0000; host_wdata_i = 32'h0; host_be_i = 4'hF;
      host_req_i = 1'b1;
      @(negedge clk_i);
      chk("abort_en", ram_en_o, 1'b1);
      #2 rst_n_i = 1'b0;
      #1 chk("abort_en_drop", ram_en_o, 1'b0);
      n = 0;
      repeat (2) begin
         @(negedge clk_i);
         if (host_ack_o || cpu_ack_o) n++;
      end
      chk("abort_no_ack", n, 0);
      ram_q.push_back({4'h0, 32'h0002_0000, 32'h0});
      exp_q.push_back({1'b1, 1'b1, 32'hDEAD_BEEF});
      rst_n_i = 1'b1;
      @(negedge clk_i);
      chk("fresh_en", ram_en_o, 1'b1);
      @(negedge clk_i);
      chk("fresh_ack_early", host_ack_o, 1'b0);
      @(negedge clk_i);
      chk("fresh_ack", host_ack_o, 1'b1);
      host_req_i = 1'b0;

      // Drain and report
      n = 0;
      while ((exp_q.size() != 0 || ram_q.size() != 0) && n < 20) begin @(negedge clk_i); n++; end
      chk("ack_q_empty", exp_q.size(), 0);
      chk("ram_q_empty", ram_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
